// File: rtl/fp32_pkg.sv
// Shared FP32 constants and sequencer state encoding used by the FMA front-end blocks.
package fp32_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_NAN      = 32'hFFFF_FFFF;
  localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

  // The FMA signals an invalid result with the all-ones pattern.
  function automatic logic fp32_is_nan_marker(input logic [31:0] v);
    return v == FP32_NAN;
  endfunction

endpackage

// File: rtl/fma_dot_sequencer.sv
// Streams operand pairs into an external FMA, accumulating d back into c,
// and presents the dot product on a valid/ready port after LEN pairs.
module fma_dot_sequencer
  import fp32_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  output logic [31:0]      fma_a,
  output logic [31:0]      fma_b,
  output logic [31:0]      fma_c,
  input  logic [31:0]      fma_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [LEN_W-1:0] out_count
);

  seq_state_t       state, state_nxt;
  logic [31:0]      acc;
  logic [LEN_W-1:0] cnt;
  logic             nan_stk;
  logic             in_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = (len == '0) ? ST_HOLD : ST_ACC;
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LEN_W'(1)) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_fire = in_valid & in_ready;

  // acc is the only register on the FMA loop: acc -> FMA c -> d -> acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= FP32_POS_ZERO;
      cnt       <= '0;
      out_count <= '0;
      nan_stk   <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      acc       <= FP32_POS_ZERO;
      cnt       <= len;
      out_count <= '0;
      nan_stk   <= 1'b0;
    end else if (in_fire) begin
      acc       <= fma_d;
      cnt       <= cnt - LEN_W'(1);
      out_count <= out_count + LEN_W'(1);
      nan_stk   <= nan_stk | fp32_is_nan_marker(fma_d);
    end
  end

  assign busy     = (state != ST_IDLE);
  assign fma_a    = in_x;
  assign fma_b    = in_y;
  assign fma_c    = acc;
  // A NaN seen on any partial wins, even if later partials come back finite.
  assign out_data = nan_stk ? FP32_NAN : acc;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer with a behavioural FP32 FMA on the fma_* ports.
module tb_fma_dot_sequencer;

  localparam logic [31:0] F05 = 32'h3F00_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F8  = 32'h4100_0000;
  localparam logic [31:0] F9  = 32'h4110_0000;
  localparam logic [31:0] F12 = 32'h4140_0000;
  localparam logic [31:0] FNAN = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, out_ready;
  logic [7:0]  len, out_count;
  logic [31:0] in_x, in_y, fma_a, fma_b, fma_c, fma_d, out_data;
  logic        busy, in_ready, out_valid;
  logic        ovr;
  logic [31:0] ovr_val, fma_model;
  int          n_checks = 0;
  int          n_fail = 0;

  fma_dot_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_d(fma_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic real to_real(input logic [31:0] v);
    real m;
    int  e;
    if (v[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(v[22:0]) / 8388608.0;
    e = int'(v[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_bits(input real r);
    logic s;
    int   e, mi;
    real  a;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mi = $rtoi((a - 1.0) * 8388608.0);
    return {s, 8'(e), 23'(mi)};
  endfunction

  // NaN operands propagate with their payload, matching the FMA beside the block.
  function automatic logic [31:0] fma_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    if (is_nan(a)) return a;
    if (is_nan(b)) return b;
    if (is_nan(c)) return c;
    return to_bits(to_real(a) * to_real(b) + to_real(c));
  endfunction

  always_comb fma_model = fma_f(fma_a, fma_b, fma_c);
  assign fma_d = ovr ? ovr_val : fma_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_pair_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic ack_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; len = 0; in_valid = 0; out_ready = 0;
    in_x = 0; in_y = 0; ovr = 0; ovr_val = 0;
    #2;
    n_checks++;
    if ({busy, in_ready, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, in_ready, out_valid});
    end
    n_checks++;
    if (fma_c !== 32'h0 || out_data !== 32'h0 || out_count !== 8'h0) begin
      n_fail++; $display("FAIL reset_data: c=%h data=%h count=%0d required 0", fma_c, out_data, out_count);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    do_start(8'd2);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || fma_c !== 32'h0) begin
      n_fail++; $display("FAIL b2b_acc_entry: busy=%b ready=%b c=%h required 1 1 0", busy, in_ready, fma_c);
    end
    in_x = F1; in_y = F3;
    #1;
    n_checks++;
    if (fma_a !== F1 || fma_b !== F3) begin
      n_fail++; $display("FAIL b2b_passthru: a=%h b=%h required %h %h", fma_a, fma_b, F1, F3);
    end
    send_pair(F1, F3);
    n_checks++;
    if (fma_c !== F3 || out_count !== 8'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_partial: c=%h count=%0d ov=%b required %h 1 0", fma_c, out_count, out_valid, F3);
    end
    send_pair(F2, F05);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    n_checks++;
    if (out_data !== F4 || out_count !== 8'd2) begin
      n_fail++; $display("FAIL b2b_result: data=%h count=%0d required %h 2", out_data, out_count, F4);
    end
    ack_out();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b ov=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] acc_exp [3];
    int gap [3];
    acc_exp[0] = 32'h0; acc_exp[1] = F4; acc_exp[2] = F8;
    gap[0] = 1; gap[1] = 2; gap[2] = 3;
    do_start(8'd3);
    for (int k = 0; k < 3; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        tick();
        n_checks++;
        if (fma_c !== acc_exp[k] || out_count !== 8'(k) || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_hold k=%0d g=%0d: c=%h count=%0d ready=%b required %h %0d 1",
                   k, g, fma_c, out_count, in_ready, acc_exp[k], k);
        end
      end
      send_pair(F2, F2);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== F12 || out_count !== 8'd3) begin
      n_fail++; $display("FAIL gap_result: ov=%b data=%h count=%0d required 1 %h 3", out_valid, out_data, out_count, F12);
    end
    ack_out();
  endtask

  task automatic test_len_zero();
    do_start(8'd0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || out_count !== 8'd0) begin
      n_fail++; $display("FAIL len0_hold: ov=%b data=%h count=%0d required 1 0 0", out_valid, out_data, out_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0 || out_count !== 8'd0) begin
        n_fail++; $display("FAIL len0_stable cyc=%0d: ov=%b data=%h count=%0d required 1 0 0", i, out_valid, out_data, out_count);
      end
    end
    ack_out();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_nan();
    do_start(8'd2);
    send_pair(FNAN, F1);
    send_pair(F1, F1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== FNAN || out_count !== 8'd2) begin
      n_fail++; $display("FAIL nan_result: ov=%b data=%h count=%0d required 1 %h 2", out_valid, out_data, out_count, FNAN);
    end
    ack_out();
  endtask

  task automatic test_nan_sticky();
    do_start(8'd3);
    send_pair(FNAN, F1);
    ovr = 1'b1; ovr_val = F1;
    send_pair(F1, F1);
    send_pair(F1, F1);
    ovr = 1'b0;
    n_checks++;
    if (fma_c !== F1) begin
      n_fail++; $display("FAIL sticky_acc: c=%h required %h", fma_c, F1);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== FNAN || out_count !== 8'd3) begin
      n_fail++; $display("FAIL sticky_result: ov=%b data=%h count=%0d required 1 %h 3", out_valid, out_data, out_count, FNAN);
    end
    ack_out();
  endtask

  task automatic test_start_ignored();
    do_start(8'd2);
    do_start(8'd5);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || out_count !== 8'd0 || fma_c !== 32'h0) begin
      n_fail++; $display("FAIL ign_acc: busy=%b ready=%b count=%0d c=%h required 1 1 0 0", busy, in_ready, out_count, fma_c);
    end
    send_pair(F1, F1);
    send_pair(F1, F1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== F2 || out_count !== 8'd2) begin
      n_fail++; $display("FAIL ign_result: ov=%b data=%h count=%0d required 1 %h 2", out_valid, out_data, out_count, F2);
    end
    do_start(8'd1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== F2 || out_count !== 8'd2) begin
      n_fail++; $display("FAIL ign_hold: ov=%b data=%h count=%0d required 1 %h 2", out_valid, out_data, out_count, F2);
    end
    start = 1'b1; len = 8'd1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ign_same_cycle: busy=%b ov=%b required 0 0", busy, out_valid);
    end
    tick();
    start = 1'b0;
    len = 8'd7;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || fma_c !== 32'h0) begin
      n_fail++; $display("FAIL ign_restart: busy=%b ready=%b c=%h required 1 1 0", busy, in_ready, fma_c);
    end
    send_pair(F2, F2);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== F4 || out_count !== 8'd1) begin
      n_fail++; $display("FAIL ign_rerun: ov=%b data=%h count=%0d required 1 %h 1", out_valid, out_data, out_count, F4);
    end
    ack_out();
  endtask

  task automatic test_reset_mid();
    do_start(8'd4);
    send_pair(F3, F3);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: busy=%b ov=%b ready=%b required 0 0 0", busy, out_valid, in_ready);
    end
    n_checks++;
    if (fma_c !== 32'h0 || out_count !== 8'd0) begin
      n_fail++; $display("FAIL midrst_state: c=%h count=%0d required 0 0", fma_c, out_count);
    end
    #1;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_no_pulse: ov=%b busy=%b required 0 0", out_valid, busy);
    end
    do_start(8'd1);
    send_pair(F3, F3);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== F9 || out_count !== 8'd1) begin
      n_fail++; $display("FAIL midrst_rerun: ov=%b data=%h count=%0d required 1 %h 1", out_valid, out_data, out_count, F9);
    end
    ack_out();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_len_zero();
    test_nan();
    test_nan_sticky();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
